primogen_seek: RTL and testbench

//   Parametrised prime generator and successor to the fixed 16-bit generator.
//   It steps through primes on a go pulse. It can also seek to the first prime
//   at or above a loaded seed.

---
 rtl/primogen_seek.sv | 140 ++++++++++++++
 tb/tb_primogen_seek.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/primogen_seek.sv
// primogen_seek: steps through primes on go, or seeks to the first prime
// at or above a loaded seed, using trial division with a serial remainder.
module primogen_seek #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] res
);

  localparam int CW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 2;
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    CHECK,
    DIV
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    c_q, c_d;
  logic [CW-1:0]    div_q, div_d;
  logic [CW-1:0]    r_q, r_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] c_lo;
  logic [PW-1:0]    sq;
  logic [CW-1:0]    r_sh;
  logic [CW-1:0]    r_nx;
  logic [CW-1:0]    seed_c;

  assign ready = ready_q;
  assign error = error_q;
  assign res   = res_q;

  // Datapath helpers: divisor square and one shift-subtract remainder step
  always_comb begin
    c_lo   = c_q[WIDTH-1:0];
    sq     = PW'(div_q) * PW'(div_q);
    r_sh   = {r_q[CW-2:0], c_lo[idx_q]};
    r_nx   = (r_sh >= div_q) ? (r_sh - div_q) : r_sh;
    seed_c = (seed < WIDTH'(2)) ? CW'(2) : CW'(seed);
  end

  // Next-state logic: request acceptance, candidate stepping, trial division
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    div_d   = div_q;
    r_d     = r_q;
    idx_d   = idx_q;
    res_d   = res_q;
    ready_d = ready_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (ready_q && load) begin
          c_d     = seed_c;
          error_d = 1'b0;
          ready_d = 1'b0;
          state_d = CAND;
        end else if (ready_q && go && !error_q) begin
          c_d     = CW'(res_q) + CW'(1);
          ready_d = 1'b0;
          state_d = CAND;
        end
      end
      CAND: begin
        if (c_q[WIDTH]) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          div_d   = CW'(2);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (sq > PW'(c_q)) begin
          res_d   = c_lo;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          r_d     = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = DIV;
        end
      end
      DIV: begin
        r_d = r_nx;
        if (idx_q == '0) begin
          if (r_nx == '0) begin
            c_d     = c_q + CW'(1);
            state_d = CAND;
          end else begin
            div_d   = div_q + CW'(1);
            state_d = CHECK;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset to idle, res=1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      div_q   <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      res_q   <= WIDTH'(1);
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      div_q   <= div_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_primogen_seek.sv
// tb_primogen_seek: directed vectors for the 16-bit and 8-bit
// prime generator instances.
module tb_primogen_seek;

  logic        clk = 1'b0;
  logic        rst;
  logic        go16, load16, rdy16, err16;
  logic [15:0] seed16, res16;
  logic        go8, load8, rdy8, err8;
  logic [7:0]  seed8, res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  primogen_seek #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16), .load(load16),
    .seed(seed16), .ready(rdy16), .error(err16), .res(res16)
  );

  primogen_seek #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .load(load8),
    .seed(seed8), .ready(rdy8), .error(err8), .res(res8)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic req(input bit w8, input bit g, input bit l,
                     input int s);
    @(negedge clk);
    if (w8) begin
      go8 = g; load8 = l; seed8 = 8'(s);
    end else begin
      go16 = g; load16 = l; seed16 = 16'(s);
    end
    @(negedge clk);
    go8 = 0; load8 = 0; go16 = 0; load16 = 0;
  endtask

  task automatic wait_ready(input bit w8, input int budget);
    int n = 0;
    while (!(w8 ? rdy8 : rdy16) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(w8 ? rdy8 : rdy16)) chk("timeout", 0, 1);
  endtask

  task automatic run(input bit w8, input bit g, input bit l,
                     input int s);
    req(w8, g, l, s);
    wait_ready(w8, 20000);
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 0;
    return 1;
  endfunction

  int exp_seq16 [12] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};

  initial begin
    int p;
    int cnt;
    rst = 1; go16 = 0; load16 = 0; seed16 = 0;
    go8 = 0; load8 = 0; seed8 = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", rdy16, 1);
    chk("rst_error", err16, 0);
    chk("rst_res", res16, 1);

    for (int i = 0; i < 12; i++) begin
      run(0, 1, 0, 0);
      chk($sformatf("go_seq%0d", i), res16, exp_seq16[i]);
    end

    run(0, 0, 1, 90);
    chk("load90", res16, 97);
    run(0, 0, 1, 97);
    chk("load97", res16, 97);
    run(0, 0, 1, 0);
    chk("load0", res16, 2);
    run(0, 0, 1, 1);
    chk("load1", res16, 2);

    run(0, 0, 1, 65520);
    chk("load65520", res16, 65521);
    chk("load65520_err", err16, 0);
    run(0, 1, 0, 0);
    chk("go_top_err", err16, 1);
    chk("go_top_res", res16, 65521);
    req(0, 1, 0, 0);
    chk("go_err_ready", rdy16, 1);
    chk("go_err_sticky", err16, 1);
    chk("go_err_res", res16, 65521);
    run(0, 0, 1, 10);
    chk("load10", res16, 11);
    chk("load10_err", err16, 0);

    req(0, 1, 0, 0);
    chk("busy_ready", rdy16, 0);
    req(0, 1, 0, 0);
    wait_ready(0, 20000);
    chk("busy_go_res", res16, 13);
    repeat (3) @(negedge clk);
    chk("busy_go_idle", rdy16, 1);
    chk("busy_go_hold", res16, 13);
    run(0, 1, 1, 50);
    chk("go_load50", res16, 53);

    req(0, 0, 1, 65000);
    repeat (4) @(negedge clk);
    chk("abort_busy", rdy16, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", rdy16, 1);
    chk("abort_res", res16, 1);
    chk("abort_err", err16, 0);
    run(0, 1, 0, 0);
    chk("abort_go", res16, 2);

    p = 2;
    cnt = 0;
    while (p < 256) begin
      run(1, 1, 0, 0);
      chk($sformatf("w8_p%0d", p), res8, p);
      cnt++;
      p++;
      while (p < 256 && !is_prime(p)) p++;
    end
    chk("w8_count", cnt, 54);
    run(1, 1, 0, 0);
    chk("w8_err", err8, 1);
    chk("w8_res", res8, 251);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
